// File: rtl/mem_stage_sram_ctrl.sv
// MEM-stage bridge from a 32-bit load/store port to a 16-bit asynchronous SRAM.
// Each access runs as two half-word phases (low, then high), each held 1+WAIT_CYCLES cycles.
module mem_stage_sram_ctrl #(
  parameter int BASE_ADDR   = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic        sram_we_n,
  output logic [15:0] sram_dq_out,
  output logic        sram_dq_oe,
  input  logic [15:0] sram_dq_in
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  localparam logic [2:0] WAIT_LAST = 3'(WAIT_CYCLES);

  state_t      state_reg, state_next;
  logic [2:0]  cnt_reg, cnt_next;
  logic        is_write_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [31:0] read_data_reg;
  logic [16:0] word_idx;
  logic        phase_last;
  logic        request;

  assign request    = rd_en | wr_en;
  assign phase_last = (cnt_reg == WAIT_LAST);
  // Addresses below the base wrap around the 17-bit word space.
  assign word_idx   = 17'((addr_reg - 32'(BASE_ADDR)) >> 2);
  assign read_data  = read_data_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      cnt_reg   <= 3'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (request) begin
          state_next = LOW;
          cnt_next   = 3'd0;
        end
      end
      LOW: begin
        if (phase_last) begin
          state_next = HIGH;
          cnt_next   = 3'd0;
        end else begin
          cnt_next = cnt_reg + 3'd1;
        end
      end
      HIGH: begin
        if (phase_last) begin
          state_next = DONE;
          cnt_next   = 3'd0;
        end else begin
          cnt_next = cnt_reg + 3'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Request is captured only in IDLE so the pipeline may change its inputs while frozen.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      is_write_reg  <= 1'b0;
      addr_reg      <= 32'd0;
      wdata_reg     <= 32'd0;
      read_data_reg <= 32'd0;
    end else begin
      if (state_reg == IDLE && request) begin
        is_write_reg <= wr_en;
        addr_reg     <= address;
        wdata_reg    <= write_data;
      end
      if (!is_write_reg && phase_last) begin
        if (state_reg == LOW)  read_data_reg[15:0]  <= sram_dq_in;
        if (state_reg == HIGH) read_data_reg[31:16] <= sram_dq_in;
      end
    end
  end

  always_comb begin
    ready       = 1'b0;
    sram_addr   = 18'd0;
    sram_we_n   = 1'b1;
    sram_dq_out = 16'd0;
    sram_dq_oe  = 1'b0;
    case (state_reg)
      IDLE: ready = !request;
      LOW: begin
        sram_addr = {word_idx, 1'b0};
        if (is_write_reg) begin
          sram_we_n   = 1'b0;
          sram_dq_oe  = 1'b1;
          sram_dq_out = wdata_reg[15:0];
        end
      end
      HIGH: begin
        sram_addr = {word_idx, 1'b1};
        if (is_write_reg) begin
          sram_we_n   = 1'b0;
          sram_dq_oe  = 1'b1;
          sram_dq_out = wdata_reg[31:16];
        end
      end
      default: ready = 1'b1;
    endcase
  end

endmodule

// File: doc/mem_stage_sram_ctrl.md
MEM_STAGE_SRAM_CTRL -- requirements
Module: mem_stage_sram_ctrl

Interface
REQ-001 Parameter BASE_ADDR, default 1024, byte address that maps to SRAM half-word address 0.
REQ-002 Parameter WAIT_CYCLES, default 1, extra cycles each SRAM half-word access phase is held; legal range 0-7.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 rd_en  input  1  MEM-stage load request.
REQ-006 wr_en  input  1  MEM-stage store request.
REQ-007 address  input  32  byte address (ALU result), word-aligned.
REQ-008 write_data  input  32  store data.
REQ-009 read_data  output  32  load result, feeds data_mem_in of the MEM/WB register.
REQ-010 ready  output  1  access complete or no access pending; pipeline freeze = ~ready.
REQ-011 sram_addr  output  18  SRAM half-word address.
REQ-012 sram_we_n  output  1  SRAM write enable, active-low.
REQ-013 sram_dq_out  output  16  SRAM write data.
REQ-014 sram_dq_oe  output  1  1 = controller drives the SRAM data bus.
REQ-015 sram_dq_in  input  16  SRAM read data.

Function
REQ-016 FSM states IDLE, LOW, HIGH, DONE; wait counter of 3 bits.
REQ-017 IDLE: if wr_en or rd_en = 1, the FSM latches the op (wr_en wins when both are set), latches address/write_data, clears the counter, and moves to LOW; otherwise it stays in IDLE.
REQ-018 LOW: counter increments each cycle; when counter = WAIT_CYCLES, the FSM clears the counter and moves to HIGH.
REQ-019 HIGH: same counting rule as LOW; at counter = WAIT_CYCLES, the FSM moves to DONE.
REQ-020 DONE: the FSM moves to IDLE unconditionally after one cycle.
REQ-021 ready = 1 in DONE, or in IDLE with rd_en = wr_en = 0; ready = 0 otherwise (combinational).
REQ-022 Latency: request seen in IDLE at cycle 0 -> ready low for 2*WAIT_CYCLES+3 cycles -> ready high in DONE (cycle 2*WAIT_CYCLES+3).
REQ-023 Word index = (latched address - BASE_ADDR) >> 2, truncated to 17 bits; sram_addr = {index, 0} in LOW, {index, 1} in HIGH, 0 in IDLE/DONE.
REQ-024 Write op: sram_we_n = 0 and sram_dq_oe = 1 for every LOW/HIGH cycle; sram_dq_out = write_data[15:0] in LOW, write_data[31:16] in HIGH.
REQ-025 In IDLE/DONE and during reads: sram_we_n = 1, sram_dq_oe = 0, sram_dq_out = 0.
REQ-026 Read op: read_data[15:0] <= sram_dq_in on the last LOW cycle; read_data[31:16] <= sram_dq_in on the last HIGH cycle.
REQ-027 read_data is registered, is valid in DONE, and holds until the next read overwrites it; writes never modify it.
REQ-028 Inputs rd_en/wr_en/address/write_data are ignored outside IDLE (latched copies are used).
REQ-029 A request present in IDLE directly after DONE starts a new access with no idle gap.
REQ-030 Addresses below BASE_ADDR wrap modulo 2^17 words; no error is signalled.

Reset
REQ-031 rst = 0 at any time, including mid-access, immediately forces state IDLE, counter 0, read_data 0, latched registers 0.
REQ-032 During and after reset: sram_we_n = 1, sram_dq_oe = 0, sram_addr = 0, sram_dq_out = 0; ready = 1 while rd_en = wr_en = 0.
REQ-033 Release of reset starts in IDLE; an aborted write leaves SRAM contents undefined, and no recovery is required.

Verification
REQ-034 Write then read, WAIT_CYCLES = 1: store 0xDEADBEEF at address 1024 -> sram_addr 0 with dq 0xBEEF, then sram_addr 1 with dq 0xDEAD; we_n low 4 cycles; ready low 5 cycles; load from 1024 returns 0xDEADBEEF in DONE.
REQ-035 Address mapping: load from address 1036 -> sram_addr 6 then 7.
REQ-036 WAIT_CYCLES = 0: load -> ready low exactly 3 cycles; WAIT_CYCLES = 7 -> low exactly 17 cycles.
REQ-037 Back-to-back: store followed by load held in IDLE right after DONE -> load begins LOW next cycle; read_data unchanged by the store.
REQ-038 Reset mid-HIGH of a write -> same cycle: we_n = 1, oe = 0, read_data = 0, ready = 1 with no request.
REQ-039 rd_en = wr_en = 1 at address 1028 with data 0x12345678 -> performed as a write (we_n low); read_data unchanged.
